// File: rtl/pr3_stream_rx.sv
// pr3_stream_rx
//   Receives the PR3 result stream, gathers FRAME_LEN words into one of two
//   ping-pong banks and replays each complete frame over a valid/ready
//   interface with start/end-of-frame markers. PR3 cannot be stalled, so a
//   frame that arrives while both banks are occupied is dropped whole and
//   counted in a saturating counter.
//
// Ports
//   clk20        stream clock, rising edge
//   reset_n      asynchronous active-low reset
//   sink_valid   input word strobe (PR3 source_valid)
//   sink_data    input word (PR3 source_data)
//   out_valid    output word valid
//   out_ready    downstream accepts the word
//   out_data     output word
//   out_sof      first word of a frame (qualified by out_valid)
//   out_eof      last word of a frame (qualified by out_valid)
//   frames_ready full banks waiting or being read (0..2)
//   ovf_count    dropped-frame counter, saturates at all-ones
module pr3_stream_rx #(
    parameter int FFT       = 11,
    parameter int FRAME_LEN = 2**(FFT-1),
    parameter int WIDTH     = 32,
    parameter int OVF_WIDTH = 16
) (
    input  logic                 clk20,
    input  logic                 reset_n,
    input  logic                 sink_valid,
    input  logic [WIDTH-1:0]     sink_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_sof,
    output logic                 out_eof,
    output logic [1:0]           frames_ready,
    output logic [OVF_WIDTH-1:0] ovf_count
);
    localparam int AW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [AW-1:0] LAST = AW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_READING} bank_st_t;
    typedef enum logic {R_IDLE, R_SEND} rd_st_t;

    logic [WIDTH-1:0]     r_mem [0:2*FRAME_LEN-1];
    logic [WIDTH-1:0]     r_ram_q;
    bank_st_t             r_bank [0:1];

    logic                 r_wr_bank;
    logic [AW-1:0]        r_wr_idx;
    logic                 r_drop;
    logic [OVF_WIDTH-1:0] r_ovf;

    rd_st_t               r_rd_st, w_rd_nx;
    logic                 r_rd_ptr;
    logic [AW-1:0]        r_q_idx;
    logic                 r_q_valid;
    logic                 r_out_valid, r_out_sof, r_out_eof;
    logic [WIDTH-1:0]     r_out_data;
    logic [1:0]           r_frames;

    logic                 w_bank_free, w_drop_start, w_wr_en, w_wr_last;
    logic                 w_start, w_eof_hs, w_adv, w_q_adv, w_rd_en;
    logic [AW-1:0]        w_rd_idx;

    // ---------------- write side ----------------
    // Frame admission looks at the registered bank state only, so a bank
    // released on this very edge still counts as busy.
    assign w_bank_free  = (r_bank[r_wr_bank] == B_EMPTY);
    assign w_drop_start = sink_valid && !r_drop && (r_wr_idx == '0) && !w_bank_free;
    assign w_wr_en      = sink_valid && !r_drop && ((r_wr_idx != '0) || w_bank_free);
    assign w_wr_last    = w_wr_en && (r_wr_idx == LAST);

    always_ff @(posedge clk20 or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_bank <= 1'b0;
            r_wr_idx  <= '0;
            r_drop    <= 1'b0;
            r_ovf     <= '0;
        end else if (sink_valid) begin
            r_wr_idx <= (r_wr_idx == LAST) ? '0 : r_wr_idx + 1'b1;
            if (w_drop_start)
                r_drop <= 1'b1;
            if (r_drop && (r_wr_idx == LAST)) begin
                r_drop <= 1'b0;
                if (r_ovf != '1)
                    r_ovf <= r_ovf + 1'b1;
            end
            if (w_wr_last)
                r_wr_bank <= ~r_wr_bank;
        end
    end

    // ---------------- read FSM ----------------
    always_ff @(posedge clk20 or negedge reset_n) begin
        if (!reset_n)
            r_rd_st <= R_IDLE;
        else
            r_rd_st <= w_rd_nx;
    end

    always_comb begin
        w_rd_nx  = r_rd_st;
        w_start  = 1'b0;
        w_eof_hs = 1'b0;
        case (r_rd_st)
            R_IDLE: begin
                if (r_bank[r_rd_ptr] == B_FULL) begin
                    w_start = 1'b1;
                    w_rd_nx = R_SEND;
                end
            end
            R_SEND: begin
                if (r_out_valid && out_ready && r_out_eof) begin
                    w_eof_hs = 1'b1;
                    w_rd_nx  = R_IDLE;
                end
            end
            default: w_rd_nx = R_IDLE;
        endcase
    end

    // The RAM output register acts as a one-word stage in front of the output
    // register; both advance together, and the next read is issued only when
    // the word already fetched moves into the output register.
    assign w_adv    = !r_out_valid || out_ready;
    assign w_q_adv  = (r_rd_st == R_SEND) && w_adv && r_q_valid;
    assign w_rd_en  = w_start || (w_q_adv && (r_q_idx != LAST));
    assign w_rd_idx = w_start ? '0 : r_q_idx + 1'b1;

    always_ff @(posedge clk20) begin
        if (w_wr_en)
            r_mem[{r_wr_bank, r_wr_idx}] <= sink_data;
        if (w_rd_en)
            r_ram_q <= r_mem[{r_rd_ptr, w_rd_idx}];
    end

    always_ff @(posedge clk20 or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr    <= 1'b0;
            r_q_idx     <= '0;
            r_q_valid   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sof   <= 1'b0;
            r_out_eof   <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (w_rd_en) begin
                r_q_idx   <= w_rd_idx;
                r_q_valid <= 1'b1;
            end else if (w_q_adv) begin
                r_q_valid <= 1'b0;
            end
            if ((r_rd_st == R_SEND) && w_adv) begin
                r_out_valid <= r_q_valid;
                r_out_sof   <= r_q_valid && (r_q_idx == '0);
                r_out_eof   <= r_q_valid && (r_q_idx == LAST);
                if (r_q_valid)
                    r_out_data <= r_ram_q;
            end
            if (w_eof_hs)
                r_rd_ptr <= ~r_rd_ptr;
        end
    end

    // ---------------- bank bookkeeping ----------------
    always_ff @(posedge clk20 or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < 2; i++)
                r_bank[i] <= B_EMPTY;
            r_frames <= '0;
        end else begin
            if (w_wr_en && (r_wr_idx == '0))
                r_bank[r_wr_bank] <= B_FILLING;
            if (w_wr_last)
                r_bank[r_wr_bank] <= B_FULL;
            if (w_start)
                r_bank[r_rd_ptr] <= B_READING;
            if (w_eof_hs)
                r_bank[r_rd_ptr] <= B_EMPTY;
            case ({w_wr_last, w_eof_hs})
                2'b10:   r_frames <= r_frames + 2'd1;
                2'b01:   r_frames <= r_frames - 2'd1;
                default: r_frames <= r_frames;
            endcase
        end
    end

    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign out_sof      = r_out_sof;
    assign out_eof      = r_out_eof;
    assign frames_ready = r_frames;
    assign ovf_count    = r_ovf;

endmodule

// File: tb/tb_pr3_stream_rx.sv
// tb_pr3_stream_rx
//   Bench for pr3_stream_rx with FFT=4 (FRAME_LEN=8) and OVF_WIDTH=2.
//   A frame-level reference model tracks bank occupancy and pushes accepted
//   words into a queue; a monitor pops and compares on every handshake.
module tb_pr3_stream_rx;
    localparam int FL = 8;

    logic        clk20 = 1'b0;
    logic        reset_n = 1'b0;
    logic        sink_valid = 1'b0;
    logic [31:0] sink_data = '0;
    logic        out_ready = 1'b0;
    logic        out_valid, out_sof, out_eof;
    logic [31:0] out_data;
    logic [1:0]  frames_ready;
    logic [1:0]  ovf_count;

    pr3_stream_rx #(.FFT(4), .FRAME_LEN(8), .WIDTH(32), .OVF_WIDTH(2)) dut (
        .clk20(clk20), .reset_n(reset_n), .sink_valid(sink_valid),
        .sink_data(sink_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sof(out_sof), .out_eof(out_eof),
        .frames_ready(frames_ready), .ovf_count(ovf_count)
    );

    always #5 clk20 = ~clk20;

    typedef struct packed {
        logic [31:0] d;
        logic        sof;
        logic        eof;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   hs_cnt = 0;
    bit   rand_rdy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Occupancy = banks holding a frame being filled, waiting or being read.
    // Decisions for the coming edge use the state before that edge.
    int m_widx = 0, m_occ = 0, m_fr = 0, m_ovf = 0;
    bit m_acc = 0, m_drop = 0, m_free = 0;

    always @(negedge clk20) begin
        if (!reset_n) begin
            m_widx = 0; m_occ = 0; m_fr = 0; m_ovf = 0;
            m_acc = 0; m_drop = 0;
            exp_q.delete();
        end else begin
            chk("frames_ready", 32'(frames_ready), 32'(m_fr));
            chk("ovf_count", 32'(ovf_count), 32'(m_ovf));
            m_free = out_valid && out_ready && out_eof;
            if (sink_valid) begin
                if (!m_acc && !m_drop) begin
                    if (m_occ < 2) begin m_acc = 1; m_occ++; end
                    else m_drop = 1;
                end
                if (m_acc) begin
                    exp_q.push_back({sink_data, m_widx == 0, m_widx == FL-1});
                    if (m_widx == FL-1) begin m_fr++; m_acc = 0; end
                end else if (m_drop && m_widx == FL-1) begin
                    m_drop = 0;
                    if (m_ovf < 3) m_ovf++;
                end
                m_widx = (m_widx + 1) % FL;
            end
            if (m_free) begin m_occ--; m_fr--; end
        end
    end

    // ---------------- monitor ----------------
    logic        pv = 1'b0, pr = 1'b0, ps = 1'b0, pe = 1'b0;
    logic [31:0] pd = '0;

    always @(negedge clk20) begin
        if (!reset_n) begin
            pv = 1'b0;
        end else begin
            if (pv && !pr) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", out_data, pd);
                chk("hold_flags", 32'({out_sof, out_eof}), 32'({ps, pe}));
            end
            if (out_valid && out_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_word: got 0x%0h, expected no word (t=%0t)", out_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("data", out_data, e.d);
                    chk("sof", 32'(out_sof), 32'(e.sof));
                    chk("eof", 32'(out_eof), 32'(e.eof));
                end
            end
            pv = out_valid; pr = out_ready; pd = out_data; ps = out_sof; pe = out_eof;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input logic v, input logic [31:0] d);
        @(posedge clk20);
        #1;
        sink_valid = v;
        sink_data  = d;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_frame(input logic [31:0] base, input int gapmax);
        for (int w = 0; w < FL; w++) begin
            cyc(1'b1, base + 32'(w));
            if (gapmax > 0)
                repeat ($urandom_range(0, gapmax)) cyc(1'b0, '0);
        end
        cyc(1'b0, '0);
    endtask

    task automatic do_reset();
        @(posedge clk20);
        #2;
        reset_n    = 1'b0;
        sink_valid = 1'b0;
        sink_data  = '0;
        out_ready  = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_sof_eof", 32'({out_sof, out_eof}), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_frames", 32'(frames_ready), 32'd0);
        chk("rst_ovf", 32'(ovf_count), 32'd0);
        @(posedge clk20);
        #2;
        reset_n = 1'b1;
    endtask

    task automatic drain(input int max);
        int i = 0;
        while ((exp_q.size() != 0 || out_valid) && i < max) begin
            cyc(1'b0, '0);
            i++;
        end
        n_cmp++;
        if (exp_q.size() != 0 || out_valid) begin
            n_fail++;
            $display("FAIL drain: %0d words still expected, out_valid=%0b", exp_q.size(), out_valid);
        end
        repeat (20) cyc(1'b0, '0);
    endtask

    int ovf_exp [5] = '{1, 2, 3, 3, 3};
    int h0;
    bit found;

    initial begin
        // 1: single frame, latency and back-to-back output
        do_reset();
        out_ready = 1'b1;
        send_frame(32'h100, 0);
        @(negedge clk20); chk("t1_lat_e0", 32'(out_valid), 32'd0);
        chk("t1_frames_1", 32'(frames_ready), 32'd1);
        @(negedge clk20); chk("t1_lat_e1", 32'(out_valid), 32'd0);
        @(negedge clk20); chk("t1_lat_e2", 32'(out_valid), 32'd1);
        for (int i = 1; i < FL; i++) begin
            @(negedge clk20); chk("t1_burst", 32'(out_valid), 32'd1);
        end
        @(negedge clk20); chk("t1_end_valid", 32'(out_valid), 32'd0);
        chk("t1_frames_0", 32'(frames_ready), 32'd0);
        drain(50);

        // 2: both banks full under backpressure, third frame dropped
        do_reset();
        send_frame(32'h100, 0);
        send_frame(32'h108, 0);
        cyc(1'b0, '0);
        chk("t2_frames_2", 32'(frames_ready), 32'd2);
        chk("t2_valid_held", 32'(out_valid), 32'd1);
        chk("t2_data_held", out_data, 32'h100);
        send_frame(32'h110, 0);
        chk("t2_ovf", 32'(ovf_count), 32'd1);
        h0 = hs_cnt;
        out_ready = 1'b1;
        drain(200);
        chk("t2_word_count", 32'(hs_cnt - h0), 32'd16);

        // 3: random backpressure, gapped input
        do_reset();
        rand_rdy = 1'b1;
        for (int f = 0; f < 4; f++)
            send_frame(32'h300 + 32'(f * FL), 3);
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        drain(400);

        // 4: reset mid-frame while a word is presented
        do_reset();
        send_frame(32'h400, 0);
        for (int w = 0; w < 6; w++) cyc(1'b1, 32'h408 + 32'(w));
        chk("t4_pre_valid", 32'(out_valid), 32'd1);
        do_reset();
        out_ready = 1'b1;
        send_frame(32'h480, 0);
        drain(100);

        // 5: bank freed on the same edge a new frame starts
        do_reset();
        send_frame(32'h500, 0);
        send_frame(32'h508, 0);
        out_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cyc(1'b0, '0);
            if (out_valid && out_eof) found = 1'b1;
        end
        chk("t5_eof_seen", 32'(found), 32'd1);
        sink_valid = 1'b1;
        sink_data  = 32'h510;
        for (int w = 1; w < FL; w++) cyc(1'b1, 32'h510 + 32'(w));
        cyc(1'b0, '0);
        chk("t5_ovf", 32'(ovf_count), 32'd1);
        send_frame(32'h518, 0);
        drain(100);

        // 6: saturation of a 2-bit drop counter
        do_reset();
        send_frame(32'h600, 0);
        send_frame(32'h608, 0);
        for (int k = 0; k < 5; k++) begin
            send_frame(32'h700 + 32'(k * FL), 0);
            chk("t6_ovf_sat", 32'(ovf_count), 32'(ovf_exp[k]));
        end
        h0 = hs_cnt;
        out_ready = 1'b1;
        drain(200);
        chk("t6_word_count", 32'(hs_cnt - h0), 32'd16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, %0d compared so far", n_cmp);
        $fatal(1, "watchdog timeout");
    end

endmodule

// File: doc/pr3_stream_rx.md
Name: pr3_stream_rx

Overview:
- Receiving end of the PR3 output stream (`source_valid`/`source_data`).
- Collects the 32-bit result words PR3 emits into whole frames of FRAME_LEN words, using a two-bank ping-pong buffer.
- Replays each frame downstream over a valid/ready handshake with start-of-frame and end-of-frame markers.
- PR3 has no backpressure. When both banks are occupied, this block drops whole incoming frames and counts each drop.

Parameters:
- FFT, 11, log2 of the transform length in PR3.
- FRAME_LEN, 2**(FFT-1), words per frame (one word per unique bin).
- WIDTH, 32, data word width; matches `source_data`.
- OVF_WIDTH, 16, width of the dropped-frame counter.

Ports:
- clk20  in  1  sample/stream clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- sink_valid  in  1  word strobe, driven by PR3 `source_valid`.
- sink_data  in  WIDTH  word, driven by PR3 `source_data`.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts the word.
- out_data  out  WIDTH  output word.
- out_sof  out  1  first word of a frame; qualified by out_valid.
- out_eof  out  1  last word of a frame; qualified by out_valid.
- frames_ready  out  2  number of full banks waiting or being read (0..2).
- ovf_count  out  OVF_WIDTH  dropped-frame counter; saturates at all-ones.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_sof=0, out_eof=0, out_data=0, frames_ready=0, ovf_count=0.
  - Both banks are EMPTY. Write bank=0, write index=0, read state=R_IDLE.
  - Asserting reset mid-frame discards any partial or unread frames.
- Frame alignment is count-based: the first `sink_valid` after reset is word 0 of a frame. Every FRAME_LEN accepted words close a frame.
- Per-bank state: EMPTY -> FILLING -> FULL -> READING -> EMPTY.
- Write side, at each `sink_valid`:
  - Write index 0 and the target bank is EMPTY: the bank becomes FILLING and the word is stored at index 0.
  - Write index 0 and the target bank is not EMPTY: enter DROP. The next FRAME_LEN words, including this one, are discarded. ovf_count increments once, at the last discarded word. Afterwards the write index returns to 0 and the write bank is retried unchanged.
  - The bank-free decision uses registered state. A bank freed on the same edge as an index-0 word arrives counts as not EMPTY, so that frame is dropped.
  - Storing word FRAME_LEN-1 sets the bank to FULL, toggles the write bank and increments frames_ready.
- Read FSM:
  - R_IDLE: when the bank at the read pointer is FULL, it becomes READING, read address 0 is issued, go to R_SEND.
  - R_SEND: out_data and flags are registered from a 1-cycle synchronous RAM. out_data/out_sof/out_eof may change only when out_valid=0 or out_ready=1. With out_ready held high the block sustains one word per cycle.
  - The handshake on the out_eof word does the following on that edge: the bank becomes EMPTY, frames_ready decrements, the read pointer toggles, and the FSM returns to R_IDLE.
  - A FULL frame in the other bank is not started back-to-back: one R_IDLE cycle separates frames.
- Latency: the first out_valid of a frame is asserted exactly 2 clk20 edges after the edge that stores word FRAME_LEN-1, provided the read side is idle.
- out_valid deasserts only after a handshake. It is never withdrawn while out_ready=0.
- frames_ready: a simultaneous increment and decrement on one edge leaves it unchanged.
- ovf_count stops at 2**OVF_WIDTH-1.
- Words are stored and replayed unmodified; no arithmetic on the data.

Test Plan (bench uses FFT=4, so FRAME_LEN=8):
1. Reset, then 8 consecutive `sink_valid` words 0x100..0x107 with out_ready=1 -> out_valid rises 2 edges after word 7. Words 0x100..0x107 appear on 8 consecutive cycles, out_sof on 0x100, out_eof on 0x107. frames_ready goes 1 -> 0 on the eof handshake.
2. out_ready=0, 16 words streamed -> frames_ready=2, out_data holds 0x100 stable. A third frame of 8 words is discarded and ovf_count=1. Release out_ready -> exactly 16 words out, in order, no third frame.
3. Random out_ready toggling (~50%), 4 frames with gaps between `sink_valid` -> every word is delivered exactly once, in order. out_data is stable whenever out_valid=1 and out_ready=0.
4. reset_n pulsed low after word 5 of a frame while out_valid=1 -> all outputs 0 immediately (async). The next `sink_valid` is treated as word 0 of a new frame.
5. Bank freed on the same edge as an index-0 word arrives -> that frame is dropped and ovf_count increments. The following frame is stored and delivered normally.
6. OVF_WIDTH=2 with 5 forced drops -> ovf_count reads 1, 2, 3, 3, 3.
